fnd_display_ctrl: RTL

Scan-multiplexed 4-digit 7-segment (FND) driver that consumes the time fields produced by the watch counter (`msec`, `sec`, `min`, `hour`) and displays them. It is the reading side of the watch time bus: it snapshots the fields once per scan frame, splits them into BCD digits, encodes segments and drives the common-anode digit enables. It sits between the watch top and the board pins.

---
 rtl/fnd_pkg.sv | 47 ++++
 rtl/fnd_display_ctrl_if.sv | 16 +
 rtl/fnd_tick_gen.sv | 25 ++
 rtl/fnd_display_ctrl.sv | 94 +++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// fnd_pkg: shared constants and types for the 4-digit 7-segment display driver.
//   - segment codes (active-low {dp,g,f,e,d,c,b,a}) for digits 0-9, dash, blank
//   - field moduli used for the range check
//   - snapshot record of the watch time bus
package fnd_pkg;

  localparam logic [7:0] SEG_DASH = 8'hBF;
  localparam logic [7:0] SEG_OFF  = 8'hFF;
  localparam logic [3:0] COM_OFF  = 4'b1111;

  localparam logic [6:0] MOD_MSEC = 7'd100;
  localparam logic [6:0] MOD_SEC  = 7'd60;
  localparam logic [6:0] MOD_MIN  = 7'd60;
  localparam logic [6:0] MOD_HOUR = 7'd24;

  // centisecond value at which the colon (dp on digit 2) switches off
  localparam logic [6:0] MSEC_HALF = 7'd50;

  typedef struct packed {
    logic       sel_hm;
    logic       blink_en;
    logic [6:0] msec;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
  } snap_t;

  // Values above 9 cannot reach here for in-range fields; show a dash anyway.
  function automatic logic [7:0] seg_code(input logic [6:0] v);
    logic [7:0] s;
    case (v)
      7'd0:    s = 8'hC0;
      7'd1:    s = 8'hF9;
      7'd2:    s = 8'hA4;
      7'd3:    s = 8'hB0;
      7'd4:    s = 8'h99;
      7'd5:    s = 8'h92;
      7'd6:    s = 8'h82;
      7'd7:    s = 8'hF8;
      7'd8:    s = 8'h80;
      7'd9:    s = 8'h90;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/fnd_display_ctrl_if.sv
// fnd_display_ctrl_if: watch time bus between the watch counter (master) and
// the display driver (slave).
//   sel_hm   : 0 = sec:msec, 1 = hour:min
//   blink_en : blank the display during the second half of each second
//   msec/sec/min/hour : time fields
interface fnd_display_ctrl_if;
  logic       sel_hm;
  logic       blink_en;
  logic [6:0] msec;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;

  modport master (output sel_hm, blink_en, msec, sec, min, hour);
  modport slave  (input  sel_hm, blink_en, msec, sec, min, hour);
endinterface

// File: rtl/fnd_tick_gen.sv
// fnd_tick_gen: digit-switch tick generator.
//   clk, reset : system clock, async active-high reset
//   scan_tick  : one-cycle pulse every CLK_HZ/SCAN_HZ cycles
module fnd_tick_gen #(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned SCAN_HZ = 1000
) (
  input  logic clk,
  input  logic reset,
  output logic scan_tick
);
  localparam int unsigned DIV   = CLK_HZ / SCAN_HZ;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] TC = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            cnt_q <= '0;
    else if (cnt_q == TC) cnt_q <= '0;
    else                  cnt_q <= cnt_q + CNT_W'(1);
  end

  assign scan_tick = (cnt_q == TC);
endmodule

// File: rtl/fnd_display_ctrl.sv
// fnd_display_ctrl: scan-multiplexed 4-digit common-anode 7-segment driver.
//   clk, reset : system clock, async active-high reset
//   tbus       : watch time bus (slave side), snapshotted once per frame
//   fnd_com    : digit enables, active-low, bit 0 = rightmost digit
//   fnd_data   : segments {dp,g,f,e,d,c,b,a}, active-low
module fnd_display_ctrl
  import fnd_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned SCAN_HZ = 1000
) (
  input  logic                     clk,
  input  logic                     reset,
  fnd_display_ctrl_if.slave        tbus,
  output logic [3:0]               fnd_com,
  output logic [7:0]               fnd_data
);

  logic       scan_tick;
  logic [1:0] dig_q, dig_d;
  logic       run_q, run_d;
  snap_t      snap_q, snap_d;
  logic [3:0] com_q, com_d;
  logic [7:0] data_q, data_d;

  logic [6:0] low_f, high_f, src_f, dig_val;
  logic       low_bad, high_bad, src_bad;

  fnd_tick_gen #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ)) u_tick (
    .clk       (clk),
    .reset     (reset),
    .scan_tick (scan_tick)
  );

  // run_q marks that the first tick after reset has been seen: that tick lights
  // digit 0 from the cleared snapshot rather than advancing the digit.
  always_comb begin
    dig_d  = dig_q;
    run_d  = run_q;
    snap_d = snap_q;
    if (scan_tick) begin
      run_d = 1'b1;
      if (run_q) begin
        dig_d = dig_q + 2'd1;
        if (dig_q == 2'd3) begin
          snap_d = '{sel_hm: tbus.sel_hm, blink_en: tbus.blink_en, msec: tbus.msec,
                     sec: tbus.sec, min: tbus.min, hour: tbus.hour};
        end
      end
    end
  end

  // Encode from the next-state digit and snapshot so that outputs, digit and
  // snapshot all change on the same edge.
  always_comb begin
    low_f    = snap_d.sel_hm ? {1'b0, snap_d.min}  : snap_d.msec;
    high_f   = snap_d.sel_hm ? {2'b0, snap_d.hour} : {1'b0, snap_d.sec};
    low_bad  = low_f  >= (snap_d.sel_hm ? MOD_MIN  : MOD_MSEC);
    high_bad = high_f >= (snap_d.sel_hm ? MOD_HOUR : MOD_SEC);
    src_f    = dig_d[1] ? high_f   : low_f;
    src_bad  = dig_d[1] ? high_bad : low_bad;
    dig_val  = dig_d[0] ? (src_f / 7'd10) : (src_f % 7'd10);

    data_d = src_bad ? SEG_DASH : seg_code(dig_val);
    // colon: dp on digit 2 for the first half second; a dash never gets it
    if (dig_d == 2'd2 && !src_bad && snap_d.msec < MSEC_HALF) data_d[7] = 1'b0;

    // msec >= 50 also covers out-of-range msec
    if (snap_d.blink_en && snap_d.msec >= MSEC_HALF) com_d = COM_OFF;
    else                                             com_d = ~(4'b0001 << dig_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dig_q  <= 2'd0;
      run_q  <= 1'b0;
      snap_q <= '0;
      com_q  <= COM_OFF;
      data_q <= SEG_OFF;
    end else begin
      dig_q  <= dig_d;
      run_q  <= run_d;
      snap_q <= snap_d;
      if (scan_tick) begin
        com_q  <= com_d;
        data_q <= data_d;
      end
    end
  end

  assign fnd_com  = com_q;
  assign fnd_data = data_q;

endmodule
